// File: rtl/sram_bist_ctrl_if.sv
// SRAM controller request/response bundle between the BIST engine (master) and the controller (slave).
// Handshake: a request transfers on a rising edge where mem & ready are both 1. rw, addr and data_f2s
// stay stable while mem=1. Read data arrives later as a single-cycle rd_valid strobe with data_s2f.
interface sram_bist_ctrl_if #(
   parameter int AW = 18,
   parameter int DW = 16
);
   logic          mem;
   logic          rw;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_f2s;
   logic          ready;
   logic [DW-1:0] data_s2f;
   logic          rd_valid;

   modport master (
      output mem, rw, addr, data_f2s,
      input  ready, data_s2f, rd_valid
   );

   modport slave (
      input  mem, rw, addr, data_f2s,
      output ready, data_s2f, rd_valid
   );
endinterface

// File: rtl/sram_bist_ctrl.sv
// SRAM BIST engine: fill / verify / single-error inject / 3-phase march over 2^AW words.
// Optional first-fail capture (fail_vld/fail_addr/fail_data) when SRAM_BIST_FAIL_LOG_EN is defined.
module sram_bist_ctrl #(
   parameter int AW = 18,
   parameter int DW = 16,
   parameter int EW = 16,
   parameter int IW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_start,
   input  logic [1:0]      i_mode,
   input  logic [1:0]      i_pat,
   input  logic [AW-1:0]   i_inj_addr,
   output logic            o_busy,
   output logic            o_done,
   output logic [EW-1:0]   o_err_cnt,
   output logic [IW-1:0]   o_inj_cnt,
   output logic [2:0]      o_state,
`ifdef SRAM_BIST_FAIL_LOG_EN
   output logic            o_fail_vld,
   output logic [AW-1:0]   o_fail_addr,
   output logic [DW-1:0]   o_fail_data,
`endif
   sram_bist_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      NEXT    = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_mode, w_mode_nxt;
   logic [1:0]    r_pat, w_pat_nxt;
   logic [1:0]    r_phase, w_phase_nxt;
   logic [AW-1:0] r_addr, w_addr_nxt;
   logic [DW-1:0] r_wdata, w_wdata_nxt;
   logic [EW-1:0] r_err_cnt, w_err_nxt;
   logic [IW-1:0] r_inj_cnt, w_inj_nxt;
   logic          w_mismatch;
   logic          w_start_acc;

   function automatic logic [DW-1:0] pat_word(input logic [AW-1:0] a, input logic [1:0] p,
                                              input logic inv);
      logic [DW-1:0] a_ext;
      logic [DW-1:0] v;
      a_ext = DW'(a);
      case (p)
         2'd0:    v = ~a_ext;
         2'd1:    v = a_ext;
         2'd2:    v = a[0] ? {(DW/2){2'b01}} : {(DW/2){2'b10}};
         default: v = '0;
      endcase
      return inv ? ~v : v;
   endfunction

   // March ph1/ph2 and plain verify are read steps; everything else starts with a write.
   function automatic logic is_read_step(input logic [1:0] m, input logic [1:0] ph);
      return (m == 2'd1) || ((m == 2'd3) && (ph != 2'd0));
   endfunction

   function automatic logic [1:0] last_phase(input logic [1:0] m);
      return (m == 2'd3) ? 2'd2 : 2'd0;
   endfunction

   assign w_start_acc = ((r_state == IDLE) || (r_state == DONE)) && i_start;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_mode    <= 2'd0;
         r_pat     <= 2'd0;
         r_phase   <= 2'd0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_err_cnt <= '0;
         r_inj_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_mode    <= w_mode_nxt;
         r_pat     <= w_pat_nxt;
         r_phase   <= w_phase_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_err_cnt <= w_err_nxt;
         r_inj_cnt <= w_inj_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_pat_nxt   = r_pat;
      w_phase_nxt = r_phase;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_err_nxt   = r_err_cnt;
      w_inj_nxt   = r_inj_cnt;
      w_mismatch  = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            w_state_nxt = IDLE;
            if (i_start) begin
               w_mode_nxt  = i_mode;
               w_pat_nxt   = i_pat;
               w_phase_nxt = 2'd0;
               w_addr_nxt  = (i_mode == 2'd2) ? i_inj_addr : '0;
               w_wdata_nxt = pat_word(w_addr_nxt, i_pat, i_mode == 2'd2);
               w_state_nxt = (i_mode == 2'd1) ? RD_REQ : WR_REQ;
               case (i_mode)
                  2'd0:    w_inj_nxt = '0;
                  2'd2:    w_inj_nxt = r_inj_cnt + IW'(1);
                  default: w_err_nxt = '0;
               endcase
            end
         end
         WR_REQ: if (bus.ready) w_state_nxt = NEXT;
         RD_REQ: if (bus.ready) w_state_nxt = RD_WAIT;
         RD_WAIT: begin
            if (bus.rd_valid) begin
               w_mismatch = bus.data_s2f !=
                            pat_word(r_addr, r_pat, (r_mode == 2'd3) && (r_phase == 2'd2));
               if (w_mismatch && (r_err_cnt != '1)) w_err_nxt = r_err_cnt + EW'(1);
               // March ph1 follows each read with the inverted write to the same word.
               if ((r_mode == 2'd3) && (r_phase == 2'd1)) begin
                  w_wdata_nxt = pat_word(r_addr, r_pat, 1'b1);
                  w_state_nxt = WR_REQ;
               end else begin
                  w_state_nxt = NEXT;
               end
            end
         end
         NEXT: begin
            if ((r_mode == 2'd2) || ((r_addr == '1) && (r_phase == last_phase(r_mode)))) begin
               w_state_nxt = DONE;
            end else begin
               if (r_addr == '1) begin
                  w_addr_nxt  = '0;
                  w_phase_nxt = r_phase + 2'd1;
               end else begin
                  w_addr_nxt  = r_addr + AW'(1);
               end
               w_wdata_nxt = pat_word(w_addr_nxt, r_pat,
                                      (r_mode == 2'd3) && (w_phase_nxt == 2'd1));
               w_state_nxt = is_read_step(r_mode, w_phase_nxt) ? RD_REQ : WR_REQ;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_busy       = (r_state != IDLE) && (r_state != DONE);
   assign o_done       = (r_state == DONE);
   assign o_err_cnt    = r_err_cnt;
   assign o_inj_cnt    = r_inj_cnt;
   assign o_state      = r_state;
   assign bus.mem      = (r_state == WR_REQ) || (r_state == RD_REQ);
   assign bus.rw       = (r_state != WR_REQ);
   assign bus.addr     = r_addr;
   assign bus.data_f2s = r_wdata;

`ifdef SRAM_BIST_FAIL_LOG_EN
   logic          r_fail_vld;
   logic [AW-1:0] r_fail_addr;
   logic [DW-1:0] r_fail_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fail_vld  <= 1'b0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
      end else if (w_start_acc && ((i_mode == 2'd1) || (i_mode == 2'd3))) begin
         r_fail_vld  <= 1'b0;
      end else if (w_mismatch && !r_fail_vld) begin
         r_fail_vld  <= 1'b1;
         r_fail_addr <= r_addr;
         r_fail_data <= bus.data_s2f;
      end
   end

   assign o_fail_vld  = r_fail_vld;
   assign o_fail_addr = r_fail_addr;
   assign o_fail_data = r_fail_data;
`else
   logic w_unused_start_acc;
   assign w_unused_start_acc = w_start_acc;
`endif

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl (AW=4, DW=8, EW=3) against a behavioural SRAM with random ready stalls.
module tb_sram_bist_ctrl;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int EW = 3;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_start;
   logic [1:0]    i_mode;
   logic [1:0]    i_pat;
   logic [AW-1:0] i_inj_addr;
   logic          o_busy;
   logic          o_done;
   logic [EW-1:0] o_err_cnt;
   logic [IW-1:0] o_inj_cnt;
   logic [2:0]    o_state;
`ifdef SRAM_BIST_FAIL_LOG_EN
   logic          o_fail_vld;
   logic [AW-1:0] o_fail_addr;
   logic [DW-1:0] o_fail_data;
`endif

   sram_bist_ctrl_if #(.AW(AW), .DW(DW)) bif ();

   sram_bist_ctrl #(.AW(AW), .DW(DW), .EW(EW), .IW(IW)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_start    (i_start),
      .i_mode     (i_mode),
      .i_pat      (i_pat),
      .i_inj_addr (i_inj_addr),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_err_cnt  (o_err_cnt),
      .o_inj_cnt  (o_inj_cnt),
      .o_state    (o_state),
`ifdef SRAM_BIST_FAIL_LOG_EN
      .o_fail_vld (o_fail_vld),
      .o_fail_addr(o_fail_addr),
      .o_fail_data(o_fail_data),
`endif
      .bus        (bif)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: optional stuck-at-0 on bit0 of word 6, optional all-zero read data.
   logic [DW-1:0] sram [16];
   int   wr_cnt = 0;
   int   rd_cnt = 0;
   int   done_cnt = 0;
   logic stall = 1'b0;
   logic stuck6 = 1'b0;
   logic zero_rd = 1'b0;

   always @(posedge clk) begin
      bif.rd_valid <= 1'b0;
      if (bif.mem && bif.ready) begin
         if (!bif.rw) begin
            sram[bif.addr] <= (stuck6 && (bif.addr == 4'd6)) ? (bif.data_f2s & 8'hFE) : bif.data_f2s;
            wr_cnt <= wr_cnt + 1;
         end else begin
            bif.rd_valid <= 1'b1;
            bif.data_s2f <= zero_rd ? 8'h00 : sram[bif.addr];
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      bif.ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (o_done) done_cnt++;
   end

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic [1:0] p, input logic [AW-1:0] ia);
      @(negedge clk);
      i_start = 1'b1; i_mode = m; i_pat = p; i_inj_addr = ia;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!o_done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 32'(n < 4000), 32'd1);
      @(negedge clk);
   endtask

   int wb, rb, db, n;

   initial begin
      reset = 1'b1; i_start = 1'b0; i_mode = 2'd0; i_pat = 2'd0; i_inj_addr = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_busy",  32'(o_busy),       32'd0);
      check("rst_done",  32'(o_done),       32'd0);
      check("rst_mem",   32'(bif.mem),      32'd0);
      check("rst_rw",    32'(bif.rw),       32'd1);
      check("rst_addr",  32'(bif.addr),     32'd0);
      check("rst_data",  32'(bif.data_f2s), 32'd0);
      check("rst_err",   32'(o_err_cnt),    32'd0);
      check("rst_inj",   32'(o_inj_cnt),    32'd0);
      check("rst_state", 32'(o_state),      32'd0);

      // fill pat0, with an ignored verify/pat1 start issued mid-run
      wb = wr_cnt; rb = rd_cnt; db = done_cnt;
      pulse_start(2'd0, 2'd0, '0);
      check("busy_after_start", 32'(o_busy), 32'd1);
      repeat (5) @(negedge clk);
      pulse_start(2'd1, 2'd1, '0);
      wait_done("fill");
      check("fill_writes",  32'(wr_cnt - wb),   32'd16);
      check("fill_reads",   32'(rd_cnt - rb),   32'd0);
      check("fill_mem0",    32'(sram[0]),       32'hFF);
      check("fill_mem5",    32'(sram[5]),       32'hFA);
      check("fill_mem15",   32'(sram[15]),      32'hF0);
      check("fill_done1",   32'(done_cnt - db), 32'd1);
      check("fill_idle",    32'(o_busy),        32'd0);
      check("fill_inj",     32'(o_inj_cnt),     32'd0);

      // verify pat0
      rb = rd_cnt; db = done_cnt;
      pulse_start(2'd1, 2'd0, '0);
      wait_done("verify");
      check("verify_err",   32'(o_err_cnt),     32'd0);
      check("verify_reads", 32'(rd_cnt - rb),   32'd16);
      check("verify_done1", 32'(done_cnt - db), 32'd1);

      // inject at 3
      wb = wr_cnt;
      pulse_start(2'd2, 2'd0, 4'h3);
      wait_done("inject");
      check("inj_writes", 32'(wr_cnt - wb), 32'd1);
      check("inj_mem3",   32'(sram[3]),     32'h03);
      check("inj_mem4",   32'(sram[4]),     32'hFB);
      check("inj_cnt",    32'(o_inj_cnt),   32'd1);
      check("inj_err",    32'(o_err_cnt),   32'd0);

      pulse_start(2'd1, 2'd0, '0);
      wait_done("verify2");
      check("verify2_err", 32'(o_err_cnt), 32'd1);
      check("verify2_inj", 32'(o_inj_cnt), 32'd1);
`ifdef SRAM_BIST_FAIL_LOG_EN
      check("log_vld",  32'(o_fail_vld),  32'd1);
      check("log_addr", 32'(o_fail_addr), 32'd3);
      check("log_data", 32'(o_fail_data), 32'h03);
`endif

      // march pat2 with word 6 bit0 stuck low
      stuck6 = 1'b1;
      wb = wr_cnt; rb = rd_cnt;
      pulse_start(2'd3, 2'd2, '0);
      wait_done("march");
      stuck6 = 1'b0;
      check("march_err",    32'(o_err_cnt),   32'd1);
      check("march_writes", 32'(wr_cnt - wb), 32'd32);
      check("march_reads",  32'(rd_cnt - rb), 32'd32);
      check("march_mem6",   32'(sram[6]),     32'h54);
      check("march_mem7",   32'(sram[7]),     32'hAA);
      check("march_inj",    32'(o_inj_cnt),   32'd1);
`ifdef SRAM_BIST_FAIL_LOG_EN
      check("mlog_addr", 32'(o_fail_addr), 32'd6);
      check("mlog_data", 32'(o_fail_data), 32'h54);
`endif

      // all reads return zero: 15 mismatches saturate a 3-bit counter
      zero_rd = 1'b1;
      pulse_start(2'd1, 2'd1, '0);
      wait_done("sat");
      zero_rd = 1'b0;
      check("sat_err", 32'(o_err_cnt), 32'd7);

      // reset during march ph1 with the controller stalled
      rb = rd_cnt;
      pulse_start(2'd3, 2'd0, '0);
      n = 0;
      while (rd_cnt == rb && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("ph1_reached", 32'(n < 2000), 32'd1);
      stall = 1'b1;
      repeat (4) @(negedge clk);
      check("stall_mem",  32'(bif.mem), 32'd1);
      check("stall_busy", 32'(o_busy),  32'd1);
      reset = 1'b1; i_start = 1'b1; i_mode = 2'd1;
      @(negedge clk);
      reset = 1'b0; i_start = 1'b0;
      check("abort_mem",   32'(bif.mem),   32'd0);
      check("abort_busy",  32'(o_busy),    32'd0);
      check("abort_err",   32'(o_err_cnt), 32'd0);
      check("abort_inj",   32'(o_inj_cnt), 32'd0);
      check("abort_state", 32'(o_state),   32'd0);
      @(negedge clk);
      check("abort_still_idle", 32'(o_busy), 32'd0);
      stall = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
